cordic_seq: RTL and testbench

- Iterative CORDIC sequencer computing cos(dataa) for a float32 angle in radians, |angle| <= 1.0.
- Shares one combinational CORDIC micro-rotation stage over ITERATIONS cycles.
- Drives the existing float-to-Q2.30 unpacker on the input side and the Q2.30-to-float packer on the output side; all three are external combinational blocks.
- Exposes a custom-instruction style start/done handshake to the processor.

---
 rtl/cordic_seq.sv | 135 +++++++++++++
 tb/tb_cordic_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq.sv
// rtl/cordic_seq.sv - iterative CORDIC cosine sequencer around external unpack/stage/pack blocks
//
// Computes cos(dataa) for a float32 angle (|angle| <= 1.0 rad). The controller only
// sequences and registers values; the unpacker (float->Q2.30), the micro-rotation
// stage and the packer (Q2.30->float) are external combinational blocks.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clk_en              global stall: low freezes every register
//   start, dataa        request and float32 angle, sampled only in IDLE
//   done, result, busy  one-cycle completion pulse, float32 cosine, activity flag
//   unp_in / unp_out    operand register to unpacker, Q2.30 angle back
//   stg_x/y/z, stg_i    current rotation state and iteration index to the stage
//   stg_x/y/z_nxt       stage outputs
//   pk_in / pk_out      x register to packer, float32 back
//
// Optional feature macro: CORDIC_SEQ_ZERO_BYPASS_EN
//   When defined, a zero Q2.30 angle skips the iterations and packs 1.0 directly.

module cordic_seq #(
    parameter int          ITERATIONS = 24,
    parameter logic [31:0] X_INIT     = 32'h26DD3B6A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result,
    output logic        busy,
    output logic [31:0] unp_in,
    input  logic [31:0] unp_out,
    output logic [31:0] stg_x,
    output logic [31:0] stg_y,
    output logic [31:0] stg_z,
    output logic [4:0]  stg_i,
    input  logic [31:0] stg_x_nxt,
    input  logic [31:0] stg_y_nxt,
    input  logic [31:0] stg_z_nxt,
    output logic [31:0] pk_in,
    input  logic [31:0] pk_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ITER,
        S_PACK,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    state_t      state;
    logic [31:0] x_q;
    logic [31:0] y_q;
    logic [31:0] z_q;
    logic [4:0]  i_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            result <= '0;
            unp_in <= '0;
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        unp_in <= dataa;
                        busy   <= 1'b1;
                        state  <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    z_q <= unp_out;
                    y_q <= '0;
                    i_q <= '0;
`ifdef CORDIC_SEQ_ZERO_BYPASS_EN
                    // cos(0) is exactly 1.0: load it and let the packer produce it
                    if (unp_out == 32'h0) begin
                        x_q   <= 32'h40000000;
                        state <= S_PACK;
                    end else begin
                        x_q   <= X_INIT;
                        state <= S_ITER;
                    end
`else
                    x_q   <= X_INIT;
                    state <= S_ITER;
`endif
                end
                S_ITER: begin
                    x_q <= stg_x_nxt;
                    y_q <= stg_y_nxt;
                    z_q <= stg_z_nxt;
                    // index saturates at the last iteration so it stays visible in PACK
                    if (i_q == LAST_ITER) begin
                        state <= S_PACK;
                    end else begin
                        i_q <= i_q + 5'd1;
                    end
                end
                S_PACK: begin
                    result <= pk_out;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stg_x = x_q;
    assign stg_y = y_q;
    assign stg_z = z_q;
    assign stg_i = i_q;
    assign pk_in = x_q;

endmodule

// File: tb/tb_cordic_seq.sv
// tb/tb_cordic_seq.sv - self-checking bench for cordic_seq with unpack/stage/pack models

module tb_cordic_seq;

    localparam int N = 24;
    localparam logic [31:0] K_Q = 32'h26DD3B6A;
`ifdef CORDIC_SEQ_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;
    logic        busy;
    logic [31:0] unp_in;
    logic [31:0] unp_out;
    logic [31:0] stg_x, stg_y, stg_z;
    logic [4:0]  stg_i;
    logic [31:0] stg_x_nxt, stg_y_nxt, stg_z_nxt;
    logic [31:0] pk_in;
    logic [31:0] pk_out;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- external block models ----------------
    function automatic logic [31:0] unpack_f(input logic [31:0] f);
        int e;
        logic [31:0] mag;
        e = int'(f[30:23]);
        if (e == 0) return 32'h0;
        mag = {8'h0, 1'b1, f[22:0]};
        if (e >= 120) mag = mag << (e - 120);
        else if (e > 96) mag = mag >> (120 - e);
        else mag = 32'h0;
        return f[31] ? (~mag + 32'd1) : mag;
    endfunction

    function automatic logic [31:0] pack_f(input logic [31:0] q);
        logic        s;
        logic [31:0] mag;
        logic [31:0] m;
        int          p;
        if (q == 32'h0) return 32'h0;
        s   = q[31];
        mag = s ? (~q + 32'd1) : q;
        p   = 0;
        for (int b = 0; b < 32; b++) if (mag[b]) p = b;
        m = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
        return {s, 8'(p - 30 + 127), m[22:0]};
    endfunction

    function automatic int atan_q(input int i);
        return $rtoi($atan(1.0 / (2.0 ** i)) * 1073741824.0 + 0.5);
    endfunction

    function automatic logic [31:0] stage_x(input logic [31:0] x, y, z, input int i);
        int sy;
        sy = int'(y) >>> i;
        return ($signed(z) >= 0) ? 32'(int'(x) - sy) : 32'(int'(x) + sy);
    endfunction

    function automatic logic [31:0] stage_y(input logic [31:0] x, y, z, input int i);
        int sx;
        sx = int'(x) >>> i;
        return ($signed(z) >= 0) ? 32'(int'(y) + sx) : 32'(int'(y) - sx);
    endfunction

    function automatic logic [31:0] stage_z(input logic [31:0] z, input int i);
        return ($signed(z) >= 0) ? 32'(int'(z) - atan_q(i)) : 32'(int'(z) + atan_q(i));
    endfunction

    assign unp_out   = unpack_f(unp_in);
    assign stg_x_nxt = stage_x(stg_x, stg_y, stg_z, int'(stg_i));
    assign stg_y_nxt = stage_y(stg_x, stg_y, stg_z, int'(stg_i));
    assign stg_z_nxt = stage_z(stg_z, int'(stg_i));
    assign pk_out    = pack_f(pk_in);

    // whole-operation reference: unpack, N rotations from (K,0), pack x
    function automatic logic [31:0] ref_cos(input logic [31:0] a);
        logic [31:0] x, y, z, nx, ny, nz;
        z = unpack_f(a);
        if (BYP && z == 32'h0) return pack_f(32'h40000000);
        x = K_Q;
        y = 32'h0;
        for (int i = 0; i < N; i++) begin
            nx = stage_x(x, y, z, i);
            ny = stage_y(x, y, z, i);
            nz = stage_z(z, i);
            x = nx; y = ny; z = nz;
        end
        return pack_f(x);
    endfunction

    function automatic logic [31:0] real_to_f(input real r);
        real m;
        int  e;
        int  mant;
        logic s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m < 1.0) begin m = m * 2.0; e--; end
        while (m >= 2.0) begin m = m / 2.0; e++; end
        mant = $rtoi(m * 8388608.0);
        return {s, 8'(e + 127), 23'(mant)};
    endfunction

    function automatic logic [31:0] rand_angle();
        if ($urandom_range(15) == 0) return 32'h0;
        return real_to_f(real'($urandom_range(2000000)) / 1000000.0 - 1.0);
    endfunction

    function automatic int exp_lat(input logic [31:0] a);
        return (BYP && unpack_f(a) == 32'h0) ? 3 : N + 3;
    endfunction

    // ---------------- DUT ----------------
    cordic_seq #(.ITERATIONS(N), .X_INIT(K_Q)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .dataa(dataa),
        .done(done), .result(result), .busy(busy),
        .unp_in(unp_in), .unp_out(unp_out),
        .stg_x(stg_x), .stg_y(stg_y), .stg_z(stg_z), .stg_i(stg_i),
        .stg_x_nxt(stg_x_nxt), .stg_y_nxt(stg_y_nxt), .stg_z_nxt(stg_z_nxt),
        .pk_in(pk_in), .pk_out(pk_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
        int d;
        d = int'(act) - int'(exp);
        if (d < 0) d = -d;
        n_cmp++;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h +/- %0d ulp", name, act, exp, tol);
        end
    endtask

    // ---------------- timeline model ----------------
    // cnt = qualified edges since the accepting edge (that edge = 1); 0 when idle
    int          m_cnt = 0;
    bit          m_byp = 1'b0;
    logic [31:0] m_pend = 32'h0;
    logic [31:0] m_result = 32'h0;
    logic [31:0] m_unp_in = 32'h0;
    int          m_stg_i = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_cnt = 0; m_result = 32'h0; m_unp_in = 32'h0; m_stg_i = 0; m_byp = 1'b0;
            end else if (clk_en) begin
                if (m_cnt == 0) begin
                    if (start) begin
                        m_cnt    = 1;
                        m_unp_in = dataa;
                        m_pend   = ref_cos(dataa);
                        m_byp    = BYP && (unpack_f(dataa) == 32'h0);
                    end
                end else if (m_cnt == N + 3) begin
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == 2) begin
                        m_stg_i = 0;
                        if (m_byp) m_cnt = N + 2;
                    end else if (m_cnt <= N + 2) begin
                        m_stg_i = (m_cnt - 2 < N - 1) ? m_cnt - 2 : N - 1;
                    end
                    if (m_cnt == N + 3) m_result = m_pend;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("done", {31'h0, done}, {31'h0, m_cnt == N + 3});
            chk("busy", {31'h0, busy}, {31'h0, m_cnt != 0});
            chk("result", result, m_result);
            chk("unp_in", unp_in, m_unp_in);
            chk("stg_i", {27'h0, stg_i}, 32'(m_stg_i));
        end
    end

    // ---------------- directed operation driver ----------------
    task automatic run_op(input logic [31:0] a, input int stall_at, input int stall_len,
                          input int restart_at, input logic [31:0] restart_a,
                          output logic [31:0] res, output int lat, output int n_done,
                          output bit busy_ok, output bit stg_i_const);
        int edges;
        int got_at;
        logic [4:0] i_at_stall;
        @(negedge clk);
        dataa = a; start = 1'b1; clk_en = 1'b1;
        edges = 0; got_at = -1; n_done = 0; busy_ok = 1'b1; res = 32'h0; lat = -1;
        stg_i_const = 1'b1; i_at_stall = 5'h0;
        while (edges < 200 && (got_at < 0 || edges < got_at + 10)) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = (edges == restart_at);
            dataa = (edges == restart_at) ? restart_a : rand_angle();
            if (stall_at > 0 && edges == stall_at) begin clk_en = 1'b0; i_at_stall = stg_i; end
            if (stall_at > 0 && edges == stall_at + stall_len) clk_en = 1'b1;
            #1;
            if (stall_at > 0 && edges > stall_at && edges <= stall_at + stall_len && stg_i != i_at_stall)
                stg_i_const = 1'b0;
            if (done) begin
                n_done++;
                if (got_at < 0) begin got_at = edges; res = result; lat = edges; end
            end
            if (got_at < 0 && !busy) busy_ok = 1'b0;
            if (got_at >= 0 && edges == got_at + 1 && busy) busy_ok = 1'b0;
        end
        start = 1'b0; clk_en = 1'b1;
    endtask

    logic [31:0] res;
    int          lat, nd;
    bit          bok, sconst;

    initial begin
        reset_n = 1'b0; clk_en = 1'b1; start = 1'b0; dataa = 32'h0;

        // model pins against hand-derived constants
        chk("pin_unpack_1", unpack_f(32'h3F800000), 32'h40000000);
        chk("pin_unpack_half", unpack_f(32'h3F000000), 32'h20000000);
        chk("pin_unpack_m1", unpack_f(32'hBF800000), 32'hC0000000);
        chk("pin_unpack_2m30", unpack_f(32'h30800000), 32'h00000001);
        chk("pin_pack_1", pack_f(32'h40000000), 32'h3F800000);
        chk("pin_pack_half", pack_f(32'h20000000), 32'h3F000000);
        chk("pin_atan0", 32'(atan_q(0)), 32'h3243F6A9);
        chk_near("pin_model_cos1", ref_cos(32'h3F800000), 32'h3F0A5140, 8);
        chk_near("pin_model_cos05", ref_cos(32'h3F000000), 32'h3F60A940, 8);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_stg_i", {27'h0, stg_i}, 32'h0);
        chk("rst_unp_in", unp_in, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // zero angle
        run_op(32'h00000000, -1, 0, -1, 32'h0, res, lat, nd, bok, sconst);
        chk("zero_lat", 32'(lat), 32'(exp_lat(32'h0)));
        chk_near("zero_res_near", res, 32'h3F800000, 8);
        if (BYP) chk("zero_res_exact", res, 32'h3F800000);

        // tiny non-zero angle always takes the full path
        run_op(32'h30800000, -1, 0, -1, 32'h0, res, lat, nd, bok, sconst);
        chk("tiny_lat", 32'(lat), 32'(N + 3));
        chk("tiny_res", res, ref_cos(32'h30800000));

        // one radian with busy profile
        run_op(32'h3F800000, -1, 0, -1, 32'h0, res, lat, nd, bok, sconst);
        chk("one_lat", 32'(lat), 32'(N + 3));
        chk_near("one_res", res, 32'h3F0A5140, 8);
        chk("one_busy_profile", {31'h0, bok}, 32'h1);

        // start retriggered at iteration 5 is ignored
        run_op(32'h3F800000, -1, 0, 7, 32'hBF800000, res, lat, nd, bok, sconst);
        chk("retrig_lat", 32'(lat), 32'(N + 3));
        chk("retrig_ndone", 32'(nd), 32'h1);
        chk("retrig_res", res, ref_cos(32'h3F800000));

        // stall mid-iteration
        run_op(32'h3F000000, 10, 7, -1, 32'h0, res, lat, nd, bok, sconst);
        chk("stall_lat", 32'(lat), 32'(N + 3 + 7));
        chk_near("stall_res", res, 32'h3F60A940, 8);
        chk("stall_stg_i_const", {31'h0, sconst}, 32'h1);
        chk("stall_ndone", 32'(nd), 32'h1);

        // reset at iteration 10 aborts the operation
        @(negedge clk);
        dataa = 32'h3F000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        chk("pre_rst_stg_i", {27'h0, stg_i}, 32'd10);
        reset_n = 1'b0;
        #1;
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_stg_i", {27'h0, stg_i}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_op(32'hBF000000, -1, 0, -1, 32'h0, res, lat, nd, bok, sconst);
        chk("post_rst_lat", 32'(lat), 32'(N + 3));
        chk("post_rst_res", res, ref_cos(32'hBF000000));

        // randomized traffic; the compare process checks every cycle
        nd = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            clk_en = ($urandom_range(9) != 0);
            start  = ($urandom_range(3) == 0);
            dataa  = rand_angle();
            #1;
            if (done && clk_en) nd++;
        end
        n_cmp++;
        if (nd < 20) begin
            n_bad++;
            $display("FAIL rand_ops: got %0d completions expected at least 20", nd);
        end

        @(negedge clk);
        start = 1'b0; clk_en = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
